// File: rtl/uart_mmio_pkg.sv
// Shared constants for the memory-mapped UART: base nibble, register offsets,
// STATUS bit positions and the 2-bit FSM state encodings used by TX and RX.
package uart_mmio_pkg;

  localparam logic [3:0] UART_BASE_NIBBLE = 4'h8;

  localparam logic [1:0] UART_STATUS  = 2'd0;
  localparam logic [1:0] UART_RX_DATA = 2'd1;
  localparam logic [1:0] UART_TX_DATA = 2'd2;

  localparam int STAT_TX_READY  = 0;
  localparam int STAT_RX_VALID  = 1;
  localparam int STAT_FRAME_ERR = 2;
  localparam int STAT_OVERRUN   = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  function automatic logic [31:0] status_word(input logic tx_ready, input logic rx_valid,
                                              input logic frame_err, input logic overrun);
    status_word = '0;
    status_word[STAT_TX_READY]  = tx_ready;
    status_word[STAT_RX_VALID]  = rx_valid;
    status_word[STAT_FRAME_ERR] = frame_err;
    status_word[STAT_OVERRUN]   = overrun;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Circular RX byte FIFO; pointers carry one extra wrap bit to tell full from empty.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped UART on the memory-stage bus. Define UART_RX_FIFO_EN to buffer
// received bytes in an RX_FIFO_DEPTH FIFO instead of a single holding register.
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter int CPU_CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE      = 115200,
  parameter int RX_FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        serial_in,
  output logic        serial_out,
  input  logic [31:0] mmio_addr,
  input  logic [31:0] mmio_wdata,
  input  logic [3:0]  mmio_we,
  input  logic        mmio_re,
  output logic [31:0] mmio_rdata
);

  localparam int CLKS_PER_BIT = CPU_CLOCK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic       sel, rd, wr;
  logic [1:0] offs;
  logic       unused_bits;

  assign sel  = (mmio_addr[31:28] == UART_BASE_NIBBLE);
  assign offs = mmio_addr[3:2];
  assign rd   = sel && mmio_re;
  assign wr   = sel && (|mmio_we);
  assign unused_bits = ^{mmio_addr[27:4], mmio_addr[1:0], mmio_wdata[31:8]};

  logic [1:0]    tx_state_reg;
  logic [CW-1:0] tx_cnt_reg;
  logic [2:0]    tx_idx_reg;
  logic [7:0]    tx_shift_reg;
  logic          tx_line_reg;
  logic          tx_ready, tx_tick;

  assign tx_ready   = (tx_state_reg == ST_IDLE);
  assign tx_tick    = (tx_cnt_reg == BIT_LAST);
  assign serial_out = tx_line_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_reg <= ST_IDLE;
      tx_cnt_reg   <= '0;
      tx_idx_reg   <= '0;
      tx_shift_reg <= '0;
      tx_line_reg  <= 1'b1;
    end else begin
      tx_cnt_reg <= (tx_state_reg == ST_IDLE || tx_tick) ? '0 : tx_cnt_reg + 1'b1;
      case (tx_state_reg)
        ST_IDLE: if (wr && offs == UART_TX_DATA) begin
          tx_shift_reg <= mmio_wdata[7:0];
          tx_line_reg  <= 1'b0;
          tx_state_reg <= ST_START;
        end
        ST_START: if (tx_tick) begin
          tx_line_reg  <= tx_shift_reg[0];
          tx_idx_reg   <= '0;
          tx_state_reg <= ST_DATA;
        end
        ST_DATA: if (tx_tick) begin
          tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
          if (tx_idx_reg == 3'd7) begin
            tx_line_reg  <= 1'b1;
            tx_state_reg <= ST_STOP;
          end else begin
            tx_line_reg <= tx_shift_reg[1];
            tx_idx_reg  <= tx_idx_reg + 1'b1;
          end
        end
        default: if (tx_tick) tx_state_reg <= ST_IDLE;
      endcase
    end
  end

  logic          sync1_reg, sync2_reg, prev_reg;
  logic [1:0]    rx_state_reg;
  logic [CW-1:0] rx_cnt_reg;
  logic [2:0]    rx_idx_reg;
  logic [7:0]    rx_shift_reg;
  logic          rx_tick, rx_push, ferr_set;

  assign rx_tick  = (rx_cnt_reg == BIT_LAST);
  assign rx_push  = (rx_state_reg == ST_STOP) && rx_tick && sync2_reg;
  assign ferr_set = (rx_state_reg == ST_STOP) && rx_tick && !sync2_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_reg    <= 1'b1;
      sync2_reg    <= 1'b1;
      prev_reg     <= 1'b1;
      rx_state_reg <= ST_IDLE;
      rx_cnt_reg   <= '0;
      rx_idx_reg   <= '0;
      rx_shift_reg <= '0;
    end else begin
      sync1_reg <= serial_in;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      case (rx_state_reg)
        ST_IDLE: begin
          rx_cnt_reg <= '0;
          if (prev_reg && !sync2_reg) rx_state_reg <= ST_START;
        end
        // Half-bit wait lands every later sample in the middle of its bit.
        ST_START: if (rx_cnt_reg == HALF_LAST) begin
          rx_cnt_reg   <= '0;
          rx_idx_reg   <= '0;
          rx_state_reg <= sync2_reg ? ST_IDLE : ST_DATA;
        end else begin
          rx_cnt_reg <= rx_cnt_reg + 1'b1;
        end
        ST_DATA: if (rx_tick) begin
          rx_cnt_reg   <= '0;
          rx_shift_reg <= {sync2_reg, rx_shift_reg[7:1]};
          rx_idx_reg   <= rx_idx_reg + 1'b1;
          if (rx_idx_reg == 3'd7) rx_state_reg <= ST_STOP;
        end else begin
          rx_cnt_reg <= rx_cnt_reg + 1'b1;
        end
        default: if (rx_tick) begin
          rx_cnt_reg   <= '0;
          rx_state_reg <= ST_IDLE;
        end else begin
          rx_cnt_reg <= rx_cnt_reg + 1'b1;
        end
      endcase
    end
  end

  logic       rx_valid, rx_full, rx_pop;
  logic [7:0] rx_dout;

  assign rx_pop = rd && (offs == UART_RX_DATA) && rx_valid;

`ifdef UART_RX_FIFO_EN
  logic fifo_empty;

  uart_rx_fifo #(.DEPTH(RX_FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_shift_reg),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (fifo_empty)
  );
  assign rx_valid = !fifo_empty;
`else
  localparam int unused_depth = RX_FIFO_DEPTH;
  logic [7:0] hold_reg;
  logic       hold_valid_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_reg       <= '0;
      hold_valid_reg <= 1'b0;
    end else if (rx_push && (!hold_valid_reg || rx_pop)) begin
      hold_reg       <= rx_shift_reg;
      hold_valid_reg <= 1'b1;
    end else if (rx_pop) begin
      hold_valid_reg <= 1'b0;
    end
  end
  assign rx_valid = hold_valid_reg;
  assign rx_full  = hold_valid_reg;
  assign rx_dout  = hold_reg;
`endif

  logic frame_err_reg, overrun_reg, status_rd;

  assign status_rd = rd && (offs == UART_STATUS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      mmio_rdata    <= '0;
    end else begin
      // A new error raised on the clearing edge survives the STATUS read.
      frame_err_reg <= ferr_set || (frame_err_reg && !status_rd);
      overrun_reg   <= (rx_push && rx_full && !rx_pop) || (overrun_reg && !status_rd);
      if (rd) begin
        case (offs)
          UART_STATUS:  mmio_rdata <= status_word(tx_ready, rx_valid, frame_err_reg, overrun_reg);
          UART_RX_DATA: mmio_rdata <= rx_valid ? {24'd0, rx_dout} : 32'd0;
          default:      mmio_rdata <= 32'd0;
        endcase
      end
    end
  end

endmodule
